// File: rtl/bit_speck128_128_hierarchy_carry_sharing_if.sv
// Purpose : share-level bus between the masking wrapper and the bit-serial Speck core.
// Ports   : serial plaintext/key/carry-seed shares, load/run enables, ciphertext shares, round flag.
// Modports: master = wrapper (drives shares and enables), slave = core.
interface bit_speck128_128_hierarchy_carry_sharing_if;
  logic       data_ina;
  logic       data_inb;
  logic       data_inc;
  logic       k_data_ina;
  logic       k_data_inb;
  logic       k_data_inc;
  logic       carry_init_a;
  logic       carry_init_b;
  logic       carry_init_c;
  logic       we;
  logic       Start;
  logic [1:0] cipher_out1;
  logic [1:0] cipher_out2;
  logic [1:0] cipher_out3;
  logic       rndlessthan32;

  modport master (
    output data_ina, data_inb, data_inc,
    output k_data_ina, k_data_inb, k_data_inc,
    output carry_init_a, carry_init_b, carry_init_c,
    output we, Start,
    input  cipher_out1, cipher_out2, cipher_out3,
    input  rndlessthan32
  );

  modport slave (
    input  data_ina, data_inb, data_inc,
    input  k_data_ina, k_data_inb, k_data_inc,
    input  carry_init_a, carry_init_b, carry_init_c,
    input  we, Start,
    output cipher_out1, cipher_out2, cipher_out3,
    output rndlessthan32
  );
endinterface

// File: rtl/bit_speck128_128_hierarchy_carry_sharing.sv
// Purpose : bit-serial three-share TI Speck128/128 encryption core (one bit per cycle).
// Ports   : clk, rst (sync, active-high), bus (slave modport: shares in, ciphertext shares out).
// Timing  : 128 load cycles (we), 2048 run cycles (Start), then ciphertext streams out LSB first.
module bit_speck128_128_hierarchy_carry_sharing (
  input logic                                        clk,
  input logic                                        rst,
  bit_speck128_128_hierarchy_carry_sharing_if.slave  bus
);

  // Per-share word state. Each word register rotates right one place per round
  // cycle; the freshly computed bit enters at [63], so after 64 cycles the new
  // word sits in natural bit order again.
  logic [63:0] x_q [3];
  logic [63:0] x_d [3];
  logic [63:0] y_q [3];
  logic [63:0] y_d [3];
  logic [63:0] l_q [3];
  logic [63:0] l_d [3];
  logic [63:0] k_q [3];
  logic [63:0] k_d [3];

  // ROR(.,8) taps: bits 0..7 of the old x/l are overwritten before the last
  // eight cycles of a round need them, so they are parked here.
  logic [7:0]  xb_q [3];
  logic [7:0]  xb_d [3];
  logic [7:0]  lb_q [3];
  logic [7:0]  lb_d [3];

  // ROL(.,3) taps: three-cycle delay of the old y/k bit leaving position 0.
  logic [2:0]  yd_q [3];
  logic [2:0]  yd_d [3];
  logic [2:0]  kd_q [3];
  logic [2:0]  kd_d [3];

  // Registered TI carry shares of the datapath (x) and key-schedule (l) adders.
  logic [2:0]  cx_q;
  logic [2:0]  cx_d;
  logic [2:0]  cl_q;
  logic [2:0]  cl_d;

  logic [5:0]  bitcnt_q;
  logic [5:0]  bitcnt_d;
  logic [5:0]  rnd_q;
  logic [5:0]  rnd_d;

  // Input shares gathered into vectors indexed by share (0=a, 1=b, 2=c).
  logic [2:0]  din;
  logic [2:0]  kin;
  logic [2:0]  cinit;

  assign din   = {bus.data_inc,     bus.data_inb,     bus.data_ina};
  assign kin   = {bus.k_data_inc,   bus.k_data_inb,   bus.k_data_ina};
  assign cinit = {bus.carry_init_c, bus.carry_init_b, bus.carry_init_a};

  // Non-complete TI majority: share s is built only from the other two share
  // indices (u = first, v = second), so no single share sees all three.
  function automatic logic ti_maj(input logic pu, input logic pv,
                                  input logic qu, input logic qv,
                                  input logic cu, input logic cv);
    return (pu & qu) ^ (pu & qv) ^ (pv & qu)
         ^ (pu & cu) ^ (pu & cv) ^ (pv & cu)
         ^ (qu & cu) ^ (qu & cv) ^ (qv & cu);
  endfunction

  // ------------------------------------------------------------------
  // Per-bit round datapath (valid whenever bitcnt_q addresses bit j)
  // ------------------------------------------------------------------
  logic [2:0] xr;      // ROR(x,8)[j]
  logic [2:0] lr;      // ROR(l,8)[j]
  logic [2:0] yl;      // ROL(y,3)[j]
  logic [2:0] kl;      // ROL(k,3)[j]
  logic [2:0] y0;      // y[j]
  logic [2:0] k0;      // k[j]
  logic [2:0] cxi;     // carry in, x adder
  logic [2:0] cli;     // carry in, l adder
  logic [2:0] xn;
  logic [2:0] yn;
  logic [2:0] ln;
  logic [2:0] kn;
  logic [2:0] cx_nxt;
  logic [2:0] cl_nxt;
  logic [5:0] rnd_sh;
  logic       rc_bit;

  assign rnd_sh = rnd_q >> bitcnt_q;
  assign rc_bit = rnd_sh[0];

  always_comb begin
    xr  = '0;
    lr  = '0;
    yl  = '0;
    kl  = '0;
    y0  = '0;
    k0  = '0;
    cxi = '0;
    cli = '0;
    xn  = '0;
    yn  = '0;
    ln  = '0;
    kn  = '0;
    for (int s = 0; s < 3; s++) begin
      xr[s]  = (bitcnt_q >= 6'd56) ? xb_q[s][0] : x_q[s][8];
      lr[s]  = (bitcnt_q >= 6'd56) ? lb_q[s][0] : l_q[s][8];
      // For j<3 the wrapped bits y[61+j] / k[61+j] have not yet been shifted out.
      yl[s]  = (bitcnt_q < 6'd3) ? y_q[s][61] : yd_q[s][0];
      kl[s]  = (bitcnt_q < 6'd3) ? k_q[s][61] : kd_q[s][0];
      y0[s]  = y_q[s][0];
      k0[s]  = k_q[s][0];
      // Carry chain restarts every word from the externally supplied seed.
      cxi[s] = (bitcnt_q == 6'd0) ? cinit[s] : cx_q[s];
      cli[s] = (bitcnt_q == 6'd0) ? cinit[s] : cl_q[s];
      xn[s]  = xr[s] ^ y0[s] ^ cxi[s] ^ k0[s];
      yn[s]  = yl[s] ^ xn[s];
      // Round constant only touches share a.
      ln[s]  = k0[s] ^ lr[s] ^ cli[s] ^ ((s == 0) ? rc_bit : 1'b0);
      kn[s]  = kl[s] ^ ln[s];
    end
  end

  always_comb begin
    cx_nxt[0] = ti_maj(xr[1], xr[2], y0[1], y0[2], cxi[1], cxi[2]);
    cx_nxt[1] = ti_maj(xr[2], xr[0], y0[2], y0[0], cxi[2], cxi[0]);
    cx_nxt[2] = ti_maj(xr[0], xr[1], y0[0], y0[1], cxi[0], cxi[1]);
    cl_nxt[0] = ti_maj(k0[1], k0[2], lr[1], lr[2], cli[1], cli[2]);
    cl_nxt[1] = ti_maj(k0[2], k0[0], lr[2], lr[0], cli[2], cli[0]);
    cl_nxt[2] = ti_maj(k0[0], k0[1], lr[0], lr[1], cli[0], cli[1]);
  end

  // ------------------------------------------------------------------
  // Next-state selection: load > round > output rotate > hold
  // ------------------------------------------------------------------
  logic round_en;
  logic done;

  assign done     = (rnd_q >= 6'd32);
  assign round_en = !bus.we && bus.Start && !done;

  always_comb begin
    bitcnt_d = bitcnt_q;
    rnd_d    = rnd_q;
    cx_d     = cx_q;
    cl_d     = cl_q;
    for (int s = 0; s < 3; s++) begin
      x_d[s]  = x_q[s];
      y_d[s]  = y_q[s];
      l_d[s]  = l_q[s];
      k_d[s]  = k_q[s];
      xb_d[s] = xb_q[s];
      lb_d[s] = lb_q[s];
      yd_d[s] = yd_q[s];
      kd_d[s] = kd_q[s];
    end

    if (bus.we) begin
      // {X,Y} and {L,K} act as 128-bit right shifters fed at [127].
      bitcnt_d = '0;
      rnd_d    = '0;
      for (int s = 0; s < 3; s++) begin
        x_d[s] = {din[s],    x_q[s][63:1]};
        y_d[s] = {x_q[s][0], y_q[s][63:1]};
        l_d[s] = {kin[s],    l_q[s][63:1]};
        k_d[s] = {l_q[s][0], k_q[s][63:1]};
      end
    end else if (round_en) begin
      bitcnt_d = bitcnt_q + 6'd1;
      if (bitcnt_q == 6'd63) begin
        rnd_d = rnd_q + 6'd1;
      end
      cx_d = cx_nxt;
      cl_d = cl_nxt;
      for (int s = 0; s < 3; s++) begin
        x_d[s]  = {xn[s], x_q[s][63:1]};
        y_d[s]  = {yn[s], y_q[s][63:1]};
        l_d[s]  = {ln[s], l_q[s][63:1]};
        k_d[s]  = {kn[s], k_q[s][63:1]};
        yd_d[s] = {y_q[s][0], yd_q[s][2:1]};
        kd_d[s] = {k_q[s][0], kd_q[s][2:1]};
        // Capture old bits 0..7 early in the round, consume them at the end.
        if ((bitcnt_q < 6'd8) || (bitcnt_q >= 6'd56)) begin
          xb_d[s] = {x_q[s][0], xb_q[s][7:1]};
          lb_d[s] = {l_q[s][0], lb_q[s][7:1]};
        end
      end
    end else if (bus.Start) begin
      // Finished: stream the ciphertext by rotating X and Y.
      for (int s = 0; s < 3; s++) begin
        x_d[s] = {x_q[s][0], x_q[s][63:1]};
        y_d[s] = {y_q[s][0], y_q[s][63:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bitcnt_q <= '0;
      rnd_q    <= '0;
      cx_q     <= '0;
      cl_q     <= '0;
      for (int s = 0; s < 3; s++) begin
        x_q[s]  <= '0;
        y_q[s]  <= '0;
        l_q[s]  <= '0;
        k_q[s]  <= '0;
        xb_q[s] <= '0;
        lb_q[s] <= '0;
        yd_q[s] <= '0;
        kd_q[s] <= '0;
      end
    end else begin
      bitcnt_q <= bitcnt_d;
      rnd_q    <= rnd_d;
      cx_q     <= cx_d;
      cl_q     <= cl_d;
      for (int s = 0; s < 3; s++) begin
        x_q[s]  <= x_d[s];
        y_q[s]  <= y_d[s];
        l_q[s]  <= l_d[s];
        k_q[s]  <= k_d[s];
        xb_q[s] <= xb_d[s];
        lb_q[s] <= lb_d[s];
        yd_q[s] <= yd_d[s];
        kd_q[s] <= kd_d[s];
      end
    end
  end

  assign bus.cipher_out1   = {x_q[0][0], y_q[0][0]};
  assign bus.cipher_out2   = {x_q[1][0], y_q[1][0]};
  assign bus.cipher_out3   = {x_q[2][0], y_q[2][0]};
  assign bus.rndlessthan32 = !done;

endmodule

// File: tb/tb_bit_speck128_128_hierarchy_carry_sharing.sv
module tb_bit_speck128_128_hierarchy_carry_sharing;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bit_speck128_128_hierarchy_carry_sharing_if bus();

  bit_speck128_128_hierarchy_carry_sharing dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] px;
    logic [63:0] py;
    logic [63:0] kl;
    logic [63:0] kk;
    logic [63:0] ex;
    logic [63:0] ey;
    bit          masked;
  } vec_t;

  vec_t tbl[5];

  // Word-level Speck128/128 reference.
  function automatic logic [127:0] speck_ref(input logic [63:0] px, input logic [63:0] py,
                                             input logic [63:0] kl0, input logic [63:0] kk0);
    logic [63:0] x, y, l, k;
    x = px; y = py; l = kl0; k = kk0;
    for (int i = 0; i < 32; i++) begin
      x = ({x[7:0], x[63:8]} + y) ^ k;
      y = {y[60:0], y[63:61]} ^ x;
      l = ({l[7:0], l[63:8]} + k) ^ 64'(i);
      k = {k[60:0], k[63:61]} ^ l;
    end
    return {x, y};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_carry(input bit masked);
    logic a, b;
    if (masked) begin
      a = 1'($urandom); b = 1'($urandom);
      bus.carry_init_a = a; bus.carry_init_b = b; bus.carry_init_c = a ^ b;
    end else begin
      bus.carry_init_a = 1'b1; bus.carry_init_b = 1'b0; bus.carry_init_c = 1'b1;
    end
  endtask

  // 128 we cycles; leaves Start untouched so callers can test we priority.
  task automatic load_vec(input vec_t v);
    logic [127:0] ps, ks;
    logic a, b;
    ps = {v.px, v.py};
    ks = {v.kl, v.kk};
    bus.we = 1'b1;
    for (int i = 0; i < 128; i++) begin
      if (v.masked) begin
        a = 1'($urandom); b = 1'($urandom);
        bus.data_ina = a; bus.data_inb = b; bus.data_inc = ps[i] ^ a ^ b;
        a = 1'($urandom); b = 1'($urandom);
        bus.k_data_ina = a; bus.k_data_inb = b; bus.k_data_inc = ks[i] ^ a ^ b;
      end else begin
        bus.data_ina = ps[i]; bus.data_inb = ps[i]; bus.data_inc = ps[i];
        bus.k_data_ina = ks[i]; bus.k_data_inb = ks[i]; bus.k_data_inc = ks[i];
      end
      drive_carry(v.masked);
      @(negedge clk);
    end
    bus.we = 1'b0;
  endtask

  // Runs until rndlessthan32 drops; returns number of rising edges taken.
  task automatic run_enc(input bit masked, input int pause_at, input int pause_len,
                         output int lat);
    int cyc;
    cyc = 0;
    lat = -1;
    bus.Start = 1'b1;
    while (cyc < 6000) begin
      drive_carry(masked);
      @(negedge clk);
      cyc++;
      if (!bus.rndlessthan32) begin
        lat = cyc;
        break;
      end
      if (cyc == pause_at) begin
        bus.Start = 1'b0;
        repeat (pause_len) begin
          drive_carry(masked);
          @(negedge clk);
          cyc++;
        end
        chk("pause_hold_rnd", 128'(bus.rndlessthan32), 128'(1));
        bus.Start = 1'b1;
      end
    end
  endtask

  // Collects 64 recombined output bits, then checks the stream repeats.
  task automatic collect(input string tag, input vec_t v);
    logic [63:0] gx, gy;
    logic [1:0]  r;
    gx = '0; gy = '0;
    for (int j = 0; j < 64; j++) begin
      r = bus.cipher_out1 ^ bus.cipher_out2 ^ bus.cipher_out3;
      gx[j] = r[1];
      gy[j] = r[0];
      @(negedge clk);
    end
    r = bus.cipher_out1 ^ bus.cipher_out2 ^ bus.cipher_out3;
    chk({tag, "_ct_x"}, 128'(gx), 128'(v.ex));
    chk({tag, "_ct_y"}, 128'(gy), 128'(v.ey));
    chk({tag, "_wrap"}, 128'(r), 128'({v.ex[0], v.ey[0]}));
    bus.Start = 1'b0;
  endtask

  initial begin
    int   lat;
    vec_t v;
    logic [1:0] r;
    logic [127:0] ref_ct;

    bus.data_ina = 0; bus.data_inb = 0; bus.data_inc = 0;
    bus.k_data_ina = 0; bus.k_data_inb = 0; bus.k_data_inc = 0;
    bus.carry_init_a = 0; bus.carry_init_b = 0; bus.carry_init_c = 0;
    bus.we = 0; bus.Start = 0;

    // Reset: one cycle.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("reset_out", {122'b0, bus.cipher_out1, bus.cipher_out2, bus.cipher_out3}, 128'b0);
    chk("reset_rndlt32", 128'(bus.rndlessthan32), 128'(1));

    // Vector table.
    tbl[0] = '{px:64'h6c61766975716520, py:64'h7469206564616d20,
               kl:64'h0f0e0d0c0b0a0908, kk:64'h0706050403020100,
               ex:64'ha65d985179783265, ey:64'h7860fedf5c570d18, masked:1'b0};
    tbl[1] = tbl[0];
    tbl[1].masked = 1'b1;
    for (int i = 2; i < 5; i++) begin
      tbl[i].px = {$urandom, $urandom};
      tbl[i].py = {$urandom, $urandom};
      tbl[i].kl = {$urandom, $urandom};
      tbl[i].kk = {$urandom, $urandom};
      ref_ct    = speck_ref(tbl[i].px, tbl[i].py, tbl[i].kl, tbl[i].kk);
      tbl[i].ex = ref_ct[127:64];
      tbl[i].ey = ref_ct[63:0];
      tbl[i].masked = 1'b1;
    end

    for (int i = 0; i < 5; i++) begin
      bus.Start = 1'b0;
      load_vec(tbl[i]);
      run_enc(tbl[i].masked, -1, 0, lat);
      chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(2048));
      if (i == 0) begin
        r = bus.cipher_out1 ^ bus.cipher_out2 ^ bus.cipher_out3;
        chk("kat_first_out", 128'(r), 128'(2'b10));
        @(negedge clk);
        r = bus.cipher_out1 ^ bus.cipher_out2 ^ bus.cipher_out3;
        chk("kat_second_out", 128'(r), 128'(2'b00));
        // Restart so collect sees bit 0 first: reload and rerun.
        bus.Start = 1'b0;
        load_vec(tbl[i]);
        run_enc(tbl[i].masked, -1, 0, lat);
      end
      collect($sformatf("vec%0d", i), tbl[i]);
    end

    // Pause 100 cycles in round 10.
    v = tbl[3];
    bus.Start = 1'b0;
    load_vec(v);
    run_enc(1'b1, 10 * 64 + 20, 100, lat);
    chk("pause_latency", 128'(lat), 128'(2148));
    collect("pause", v);

    // Abort at round 5 by reloading while Start stays high.
    v = tbl[4];
    bus.Start = 1'b0;
    load_vec(tbl[2]);
    bus.Start = 1'b1;
    repeat (5 * 64 + 9) begin
      drive_carry(1'b1);
      @(negedge clk);
    end
    chk("abort_midrun_rndlt32", 128'(bus.rndlessthan32), 128'(1));
    load_vec(v);
    run_enc(1'b1, -1, 0, lat);
    chk("reload_latency", 128'(lat), 128'(2048));
    collect("reload", v);

    // Reset during round 20.
    bus.Start = 1'b0;
    load_vec(tbl[2]);
    bus.Start = 1'b1;
    repeat (20 * 64 + 17) begin
      drive_carry(1'b1);
      @(negedge clk);
    end
    bus.we = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.we = 1'b0;
    bus.Start = 1'b0;
    chk("midreset_out", {122'b0, bus.cipher_out1, bus.cipher_out2, bus.cipher_out3}, 128'b0);
    chk("midreset_rndlt32", 128'(bus.rndlessthan32), 128'(1));

    // After reset the counters restart from zero: a full run again takes 2048 cycles.
    load_vec(tbl[0]);
    run_enc(1'b0, -1, 0, lat);
    chk("post_reset_latency", 128'(lat), 128'(2048));
    collect("post_reset", tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
